instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Inverse of the opcode control decoder: packs symbolic instruction requests (op class plus register/immediate/target fields) into 32-bit MIPS words.
- Covers the supported subset: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, sll.
- Buffers encoded words in a small FIFO and streams them, with sequential word addresses, to the instruction-memory loader port.
- Used by the self-test program loader to build programs for the single-cycle/pipelined core.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- BASE_ADDR, 32'h0000_3000, address of the first emitted word.
- MAX_WORDS, 1024, total words accepted before the block reports full.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; same effect as reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  4  op class: 0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 j, 8 jal, 9 jr, 10 sll; 11–15 illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target index.
- out_valid  out  1  word available.
- out_ready  in  1  memory side consumes when out_valid && out_ready.
- out_addr  out  32  byte address of out_word.
- out_word  out  32  encoded instruction.
- words_accepted  out  $clog2(MAX_WORDS+1)  legal words accepted since reset/clear.
- mem_full  out  1  words_accepted == MAX_WORDS.
- bad_op  out  1  sticky: an illegal op was accepted.

Behaviour:
- Encoding (combinational on input):
  - R-type (opcode 0): addu funct 0x21; subu funct 0x23; sll funct 0x00; jr funct 0x08.
  - I-type: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F.
  - J-type: j 0x02, jal 0x03.
- Field layout: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], target[25:0].
- Unused fields are forced to 0:
  - addu/subu: shamt.
  - sll: rs.
  - jr: rt, rd, shamt.
  - lui: rs.
  - I-type: no other forcing.
- Handshake and FIFO:
  - in_ready = !fifo_full && !mem_full.
  - A push on a full FIFO is never taken, even in a cycle with a simultaneous pop.
  - A legal accept pushes {addr_ctr, word} into the FIFO, then addr_ctr += 4 and words_accepted += 1.
  - An illegal accept completes the handshake, sets bad_op, pushes nothing and leaves addr_ctr and words_accepted unchanged.
- Output side:
  - out_valid = FIFO not empty; out_addr/out_word come from the registered FIFO head.
  - Latency: a word accepted in cycle N is visible on out_valid in cycle N+1 when the FIFO was empty.
  - Output is held stable while out_valid && !out_ready.
  - Simultaneous push and pop with the FIFO neither empty nor full: occupancy unchanged, order preserved.
- FIFO pointers are log2(DEPTH)+1 bits: wrap on the low bits; full/empty from the MSB comparison.
- Capacity: once mem_full=1, in_ready stays 0 until reset/clear. The FIFO still drains normally. addr_ctr never exceeds BASE_ADDR + 4*MAX_WORDS.
- Reset values (async reset or sync clear, including mid-stream; FIFO contents discarded):
  - in_ready=1, out_valid=0, out_addr=0, out_word=0.
  - words_accepted=0, mem_full=0, bad_op=0, addr_ctr=BASE_ADDR.

Decomposition:
- Shared package/header instr_enc_pkg: op-class enum codes, opcode and funct constants, BASE_ADDR default. The decoder's existing opcode defines are sourced from here.
- Sub-module instr_word_pack: purely combinational field packer/masker plus a legal flag.
- The top level keeps the FIFO, counters and handshake inline.

Test Plan:
- After reset, addu rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_addr=0x3000, out_word=0x00221821; words_accepted=1.
- ori rt=8 rs=0 imm=0x1234 -> 0x34081234. Then lui rs=5 rt=1 imm=0xFFFF -> 0x3C01FFFF (rs masked). Addresses 0x3000 and 0x3004.
- sll rd=2 rt=1 shamt=4 rs=7 -> 0x00011100. jal target=0x0C00 -> 0x0C000C00. jr rs=31 rt=3 -> 0x03E00008.
- out_ready=0, push 5 requests with DEPTH=4 -> in_ready=0 after the 4th and the 5th is held. Raise out_ready -> 5 words emerge in order at 0x3000..0x3010, one per cycle.
- in_op=4'hF -> handshake completes, bad_op=1 stays set, no output. Next legal op appears at the unchanged address.
- MAX_WORDS=3: after 3 legal accepts mem_full=1 and in_ready=0. Assert reset mid-drain -> outputs return to reset values immediately (asynchronously), out_valid=0, addr_ctr=0x3000.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared encoding constants for the MIPS subset: op-class codes, opcodes, funct codes
// and field-packing helpers used by both the encoder and the opcode decoder.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADDU = 4'd0,
    OP_SUBU = 4'd1,
    OP_ORI  = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_BEQ  = 4'd5,
    OP_LUI  = 4'd6,
    OP_J    = 4'd7,
    OP_JAL  = 4'd8,
    OP_JR   = 4'd9,
    OP_SLL  = 4'd10
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } fifo_entry_t;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request and memory-loader handshake bundle for the instruction stream encoder.
interface instr_stream_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_word;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_addr, out_word
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_addr, out_word
  );
endinterface

// File: rtl/instr_word_pack.sv
// Combinational packer: turns an op class plus raw fields into a 32-bit MIPS word,
// zeroing fields the instruction does not use, and flags illegal op classes.
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADDU: word = rtype(rs, rt, rd, 5'd0, FN_ADDU);
      OP_SUBU: word = rtype(rs, rt, rd, 5'd0, FN_SUBU);
      OP_SLL:  word = rtype(5'd0, rt, rd, shamt, FN_SLL);
      OP_JR:   word = rtype(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ORI:  word = itype(OPC_ORI, rs, rt, imm);
      OP_LW:   word = itype(OPC_LW, rs, rt, imm);
      OP_SW:   word = itype(OPC_SW, rs, rt, imm);
      OP_BEQ:  word = itype(OPC_BEQ, rs, rt, imm);
      OP_LUI:  word = itype(OPC_LUI, 5'd0, rt, imm);
      OP_J:    word = {OPC_J, target};
      OP_JAL:  word = {OPC_JAL, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes instruction requests, buffers {address, word} pairs in a small FIFO and
// streams them to the instruction-memory loader at sequential word addresses.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          MAX_WORDS = 1024,
  localparam int         WAW       = $clog2(MAX_WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  instr_stream_encoder_if.slave  bus,
  output logic [WAW-1:0]         words_accepted,
  output logic                   mem_full,
  output logic                   bad_op
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [31:0]     addr_ctr_reg;
  logic [WAW-1:0]  words_reg;
  logic            bad_op_reg;
  fifo_entry_t     mem [DEPTH];
  fifo_entry_t     head_reg, head_next, push_entry;
  logic [31:0]     packed_word;
  logic            legal;
  logic            fifo_empty, fifo_full, in_ready_int, accept, push, pop;

  instr_word_pack u_pack (
    .op     (bus.in_op),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .shamt  (bus.in_shamt),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .word   (packed_word),
    .legal  (legal)
  );

  assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign mem_full     = (words_reg == WAW'(MAX_WORDS));
  assign in_ready_int = !fifo_full && !mem_full;
  assign accept       = bus.in_valid && in_ready_int;
  assign push         = accept && legal;
  assign pop          = !fifo_empty && bus.out_ready;
  assign push_entry   = '{addr: addr_ctr_reg, word: packed_word};

  // The head register is loaded from the post-update read pointer, forwarding the
  // entry being written when it lands in the slot that becomes the new head.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW + 1)'(push);
    rd_ptr_next = rd_ptr_reg + (AW + 1)'(pop);
    head_next   = '0;
    if (wr_ptr_next != rd_ptr_next) begin
      if (push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
        head_next = push_entry;
      else
        head_next = mem[rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      head_reg     <= '0;
      addr_ctr_reg <= BASE_ADDR;
      words_reg    <= '0;
      bad_op_reg   <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      head_reg     <= '0;
      addr_ctr_reg <= BASE_ADDR;
      words_reg    <= '0;
      bad_op_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
      if (push) begin
        addr_ctr_reg <= addr_ctr_reg + 32'd4;
        words_reg    <= words_reg + WAW'(1);
      end
      if (accept && !legal)
        bad_op_reg <= 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_addr    = head_reg.addr;
  assign bus.out_word    = head_reg.word;
  assign words_accepted  = words_reg;
  assign bad_op          = bad_op_reg;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: a default instance for encoding, ordering
// and backpressure, and a MAX_WORDS=3 instance for capacity and async reset.
module tb_instr_stream_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  instr_stream_encoder_if bus1 ();
  instr_stream_encoder_if bus2 ();

  logic [10:0] words1;
  logic        mem_full1, bad_op1;
  logic [1:0]  words2;
  logic        mem_full2, bad_op2;

  instr_stream_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000), .MAX_WORDS(1024)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus1),
    .words_accepted(words1), .mem_full(mem_full1), .bad_op(bad_op1)
  );

  instr_stream_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000), .MAX_WORDS(3)) u_dut2 (
    .clk(clk), .reset(reset), .clear(1'b0), .bus(bus2),
    .words_accepted(words2), .mem_full(mem_full2), .bad_op(bad_op2)
  );

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_addr = 32'h0000_3000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pops happen on the posedge following a negedge where valid && ready is seen.
  always @(negedge clk) begin
    if (!reset && bus1.out_valid && bus1.out_ready) begin
      if (sb.size() == 0) begin
        chk("out_unexpected", 64'(bus1.out_valid), 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("out_addr", 64'(bus1.out_addr), 64'(e[63:32]));
        chk("out_word", 64'(bus1.out_word), 64'(e[31:0]));
        $display("pop addr=%h word=%h", bus1.out_addr, bus1.out_word);
      end
      n_pop++;
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic lg, input logic [31:0] exp_word);
    logic ok;
    bus1.in_op = op; bus1.in_rs = rs; bus1.in_rt = rt; bus1.in_rd = rd;
    bus1.in_shamt = sh; bus1.in_imm = imm; bus1.in_target = tgt;
    bus1.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 64'(bus1.in_ready), 64'd1);
    end else begin
      @(posedge clk);
      $display("push op=%0d legal=%0d exp=%h", op, lg, exp_word);
      if (lg) begin
        sb.push_back({exp_addr, exp_word});
        exp_addr += 32'd4;
      end
    end
    #1 bus1.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus1.in_valid = 0; bus1.in_op = 0; bus1.in_rs = 0; bus1.in_rt = 0; bus1.in_rd = 0;
    bus1.in_shamt = 0; bus1.in_imm = 0; bus1.in_target = 0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.in_op = 0; bus2.in_rs = 0; bus2.in_rt = 0; bus2.in_rd = 0;
    bus2.in_shamt = 0; bus2.in_imm = 0; bus2.in_target = 0; bus2.out_ready = 0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 64'(bus1.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_out_addr", 64'(bus1.out_addr), 64'd0);
    chk("rst_out_word", 64'(bus1.out_word), 64'd0);
    chk("rst_words", 64'(words1), 64'd0);
    chk("rst_mem_full", 64'(mem_full1), 64'd0);
    chk("rst_bad_op", 64'(bad_op1), 64'd0);

    // Encoding and first-word latency
    bus1.out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1821);
    chk("lat_out_valid", 64'(bus1.out_valid), 64'd1);
    chk("lat_out_addr", 64'(bus1.out_addr), 64'h3000);
    chk("lat_out_word", 64'(bus1.out_word), 64'h0022_1821);
    chk("lat_words", 64'(words1), 64'd1);
    send(4'd2, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3408_1234);
    send(4'd6, 5'd5, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h3C01_FFFF);
    send(4'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 32'h0001_1100);
    send(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0C00, 1'b1, 32'h0C00_0C00);
    send(4'd9, 5'd31, 5'd3, 5'd9, 5'd2, 16'h0, 26'h0, 1'b1, 32'h03E0_0008);
    send(4'd1, 5'd4, 5'd5, 5'd6, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0085_3023);
    send(4'd3, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h8FA8_0010);
    send(4'd4, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'hAFA9_0004);
    send(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b1, 32'h1022_FFFE);
    send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 32'h0BFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_words", 64'(words1), 64'd11);

    // Backpressure: four fill the FIFO, the fifth is held
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send(4'd0, 5'd0, 5'd0, 5'(k), 5'd0, 16'h0, 26'h0, 1'b1, {16'h0, 5'(k), 11'h021});
    chk("bp_in_ready", 64'(bus1.in_ready), 64'd0);
    chk("bp_head_addr", 64'(bus1.out_addr), 64'h302C);
    fork
      send(4'd0, 5'd0, 5'd0, 5'd5, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0000_2821);
      begin
        int p0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_ready", 64'(bus1.in_ready), 64'd0);
        chk("bp_held_word", 64'(bus1.out_word), 64'h0000_0821);
        chk("bp_held_words", 64'(words1), 64'd15);
        p0 = n_pop;
        bus1.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_pop_rate", 64'(n_pop - p0), 64'd5);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Illegal op: handshake completes, nothing emitted, address unchanged
    send(4'hF, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 32'h0);
    chk("ill_bad_op", 64'(bad_op1), 64'd1);
    chk("ill_words", 64'(words1), 64'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("ill_bad_op_sticky", 64'(bad_op1), 64'd1);
    chk("ill_no_out", 64'(bus1.out_valid), 64'd0);
    send(4'd2, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3408_1234);
    chk("ill_next_addr", 64'(bus1.out_addr), 64'h3040);
    repeat (2) @(posedge clk);

    // Synchronous clear with words still buffered
    #1 bus1.out_ready = 1'b0;
    send(4'd0, 5'd0, 5'd0, 5'd1, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0000_0821);
    send(4'd0, 5'd0, 5'd0, 5'd2, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0000_1021);
    chk("clr_pre_valid", 64'(bus1.out_valid), 64'd1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    sb.delete();
    exp_addr = 32'h0000_3000;
    chk("clr_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("clr_out_word", 64'(bus1.out_word), 64'd0);
    chk("clr_out_addr", 64'(bus1.out_addr), 64'd0);
    chk("clr_words", 64'(words1), 64'd0);
    chk("clr_bad_op", 64'(bad_op1), 64'd0);
    chk("clr_in_ready", 64'(bus1.in_ready), 64'd1);
    bus1.out_ready = 1'b1;
    send(4'd9, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'h03E0_0008);
    chk("clr_next_addr", 64'(bus1.out_addr), 64'h3000);
    repeat (2) @(posedge clk);

    // Capacity limit on the MAX_WORDS=3 instance, then async reset mid-drain
    #1;
    bus2.in_op = 4'd0; bus2.in_rs = 5'd1; bus2.in_rt = 5'd2; bus2.in_rd = 5'd3;
    bus2.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("cap_words", 64'(words2), 64'd3);
    chk("cap_mem_full", 64'(mem_full2), 64'd1);
    chk("cap_in_ready", 64'(bus2.in_ready), 64'd0);
    chk("cap_out_addr", 64'(bus2.out_addr), 64'h3000);
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("cap_drain_addr", 64'(bus2.out_addr), 64'h3004);
    chk("cap_drain_word", 64'(bus2.out_word), 64'h0022_1821);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus2.out_valid), 64'd0);
    chk("arst_out_addr", 64'(bus2.out_addr), 64'd0);
    chk("arst_out_word", 64'(bus2.out_word), 64'd0);
    chk("arst_words", 64'(words2), 64'd0);
    chk("arst_mem_full", 64'(mem_full2), 64'd0);
    chk("arst_in_ready", 64'(bus2.in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    exp_addr = 32'h0000_3000;
    bus2.out_ready = 1'b0;
    bus2.in_valid = 1'b1;
    @(posedge clk);
    #1 bus2.in_valid = 1'b0;
    chk("arst_next_addr", 64'(bus2.out_addr), 64'h3000);
    chk("arst_next_word", 64'(bus2.out_word), 64'h0022_1821);
    chk("arst_next_words", 64'(words2), 64'd1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
